coherence_bus_ctrl: RTL

Two-core snooping bus controller between the per-core instruction/data caches and the single-ported RAM. Arbitrates icache fetches, dcache writebacks and dcache coherence transactions. Drives snoops into the non-requesting dcache (ccwait/ccinv/ccsnoopaddr). Forwards a dirty block cache-to-cache while writing it back to RAM in the same beats. Blocks are 2 words; the requesting cache sequences its own word addresses.

---
 rtl/coherence_bus_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping bus controller: arbitrates icache fetches, dcache
// writebacks and coherence misses onto one RAM port, with c2c forwarding.
module coherence_bus_ctrl #(
  parameter int SNOOP_LAT = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0][31:0] iload,
  output logic [1:0]       iwait,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0][31:0] dload,
  output logic [1:0]       dwait,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  typedef enum logic [3:0] {
    IDLE, SNOOP, C2C0, C2C1, RD0, RD1,
    WB0, WB1, IFETCH
  } state_t;

  localparam logic [1:0] ACCESS  = 2'd2;
  localparam logic [7:0] LAT_END = 8'(SNOOP_LAT - 1);

  state_t     state, state_n;
  logic       g, g_n, s;
  logic       last_d, last_d_n;
  logic       last_i, last_i_n;
  logic [7:0] cnt, cnt_n;
  logic       acc;
  logic [1:0] wb_req, coh_req;

  assign acc     = (ramstate == ACCESS);
  assign s       = ~g;
  assign wb_req  = dWEN & ~cctrans;
  assign coh_req = cctrans & dREN;

  // On a tie the core that was not granted last wins.
  function automatic logic pick(
    input logic [1:0] req,
    input logic       last
  );
    pick = (&req) ? ~last : req[1];
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      g      <= 1'b0;
      cnt    <= '0;
      last_d <= 1'b0;
      last_i <= 1'b0;
    end else begin
      state  <= state_n;
      g      <= g_n;
      cnt    <= cnt_n;
      last_d <= last_d_n;
      last_i <= last_i_n;
    end
  end

  always_comb begin
    state_n  = state;
    g_n      = g;
    cnt_n    = cnt;
    last_d_n = last_d;
    last_i_n = last_i;
    unique case (state)
      IDLE: begin
        if (|wb_req) begin
          g_n      = pick(wb_req, last_d);
          last_d_n = g_n;
          state_n  = WB0;
        end else if (|coh_req) begin
          g_n      = pick(coh_req, last_d);
          last_d_n = g_n;
          cnt_n    = '0;
          state_n  = SNOOP;
        end else if (|iREN) begin
          g_n      = pick(iREN, last_i);
          last_i_n = g_n;
          state_n  = IFETCH;
        end
      end
      SNOOP: begin
        if (!(cctrans[g] && dREN[g])) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == LAT_END) begin
          cnt_n   = '0;
          state_n = ccwrite[s] ? C2C0 : RD0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      WB0:    if (acc) state_n = WB1;
      WB1:    if (acc) state_n = IDLE;
      RD0:    if (acc) state_n = RD1;
      RD1:    if (acc) state_n = IDLE;
      C2C0:   if (acc) state_n = C2C1;
      C2C1:   if (acc) state_n = IDLE;
      IFETCH: if (acc) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    iload       = '0;
    dload       = '0;
    iwait       = 2'b11;
    dwait       = 2'b11;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    if (state inside {SNOOP, C2C0, C2C1, RD0, RD1}) begin
      ccwait[s]      = 1'b1;
      ccinv[s]       = ccwrite[g];
      ccsnoopaddr[s] = daddr[g];
    end
    unique case (state)
      WB0, WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[g];
        ramstore = dstore[g];
        dwait[g] = ~acc;
      end
      // Snooper's dirty word goes to RAM and the requester at once.
      C2C0, C2C1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[s];
        ramstore = dstore[s];
        dload[g] = dstore[s];
        if (acc) dwait = 2'b00;
      end
      RD0, RD1: begin
        ramREN   = 1'b1;
        ramaddr  = daddr[g];
        dload[g] = ramload;
        dwait[g] = ~acc;
      end
      IFETCH: begin
        ramREN   = 1'b1;
        ramaddr  = iaddr[g];
        iload[g] = ramload;
        iwait[g] = ~acc;
      end
      default: ;
    endcase
  end

endmodule
